hpdcache_flush_wb: RTL and testbench
====================================

Name: hpdcache_flush_wb

Overview:
- Downstream consumer of the CMO handler's flush allocation queue.
- Accepts one dirty-line flush request at a time (nline, way, inval).
- Reads the line from the data array word by word into a line buffer, then updates the directory: clear dirty, or invalidate if inval=1.
- Emits the line to memory as one write request plus WORDS data beats, and tracks outstanding writes by ID until acknowledged.
- Provides empty status for fences and a line-conflict check for the miss path.

Parameters:
- NLINE_W, 40, line address width.
- SET_W, 7, set index width (nline[SET_W-1:0]).
- WAYS, 4, associativity (one-hot way vector width).
- WORDS, 4, data words per cache line (>=2).
- WORD_W, 64, data word width.
- CL_OFF_W, 5, byte offset width inside a line.
- MAX_OUT, 4, max outstanding memory writes (power of 2).
- ID_W, 2, memory transaction ID width, equal to log2(MAX_OUT).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- alloc_i  in  1  flush request valid
- alloc_ready_o  out  1  flush request accepted
- alloc_nline_i  in  NLINE_W  line to flush
- alloc_way_i  in  WAYS  one-hot way holding the line
- alloc_inval_i  in  1  invalidate instead of clean after read
- data_read_o  out  1  data array read strobe
- data_read_set_o  out  SET_W  read set
- data_read_way_o  out  WAYS  read way
- data_read_word_o  out  log2(WORDS)  word index
- data_read_data_i  in  WORD_W  read data, valid 1 cycle after strobe
- dir_update_o  out  1  directory update strobe
- dir_update_set_o  out  SET_W  update set
- dir_update_way_o  out  WAYS  update way
- dir_update_inval_o  out  1  1 = clear valid, 0 = clear dirty only
- mem_req_valid_o  out  1  write request valid
- mem_req_ready_i  in  1  write request ready
- mem_req_addr_o  out  NLINE_W+CL_OFF_W  line byte address ({nline, zeros})
- mem_req_id_o  out  ID_W  transaction ID
- mem_data_valid_o  out  1  write data beat valid
- mem_data_ready_i  in  1  write data beat ready
- mem_data_o  out  WORD_W  beat data
- mem_data_last_o  out  1  last beat
- mem_resp_valid_i  in  1  write acknowledge
- mem_resp_id_i  in  ID_W  acknowledged ID
- check_nline_i  in  NLINE_W  line to check for conflict
- check_hit_o  out  1  line is in flight
- empty_o  out  1  idle and no outstanding writes

Behaviour:
- Reset: FSM=IDLE, all valid/strobe outputs 0, outstanding table cleared, counters 0, empty_o=1, alloc_ready_o=1. Asynchronous reset mid-operation abandons the current line with no partial writes resumed.
- alloc_ready_o = (state==IDLE) and at least one free table entry, computed from registered state only.
- Acceptance on alloc_i & alloc_ready_o latches nline/way/inval, picks the lowest free table index as ID, marks it busy with its nline, and moves to READ.
- READ: issue data_read_o for word 0..WORDS-1 on consecutive cycles, always (the data array has no backpressure).
  - Each word is captured into line buffer[idx] the cycle after its strobe.
  - In the cycle of the last strobe, assert dir_update_o with the latched set/way and dir_update_inval_o = latched inval.
  - The cycle after, capture the last word and go to SEND_REQ.
  - READ lasts WORDS+1 cycles in total.
- SEND_REQ: mem_req_valid_o=1 with addr={nline, CL_OFF_W'0}, id = allocated ID. Held stable until mem_req_ready_i, then go to SEND_DATA.
- SEND_DATA: mem_data_valid_o=1, mem_data_o=buffer[beat]. Each handshake increments beat. mem_data_last_o=1 when beat==WORDS-1. The last handshake returns the FSM to IDLE.
- A new alloc may be accepted the cycle after return to IDLE.
- Response: mem_resp_valid_i frees entry mem_resp_id_i in the next cycle.
  - A response for a non-busy entry is ignored; it fires an assertion in simulation.
  - A response and an allocation to different entries in the same cycle both take effect.
- check_hit_o: combinational. Asserted when any busy entry's nline == check_nline_i, or when the FSM is not IDLE and latched nline == check_nline_i. It covers a line from acceptance until its acknowledge.
- empty_o = (state==IDLE) and no busy entries.
- When all MAX_OUT entries are busy, alloc_ready_o=0 until a response arrives. No reordering of acknowledgements is assumed.

Decomposition:
- hpdcache_pkg gains: hpdcache_flush_wb_fsm_t (IDLE, READ, SEND_REQ, SEND_DATA), and a struct for a flush table entry (valid, nline).
- Natural sub-module: hpdcache_flush_wb_table. It holds the MAX_OUT-entry ID/nline table with free-index priority encoder, alloc/free ports, the CAM check, and the empty flag.

Test Plan:
- Single clean flush, nline=0x123, way=4'b0010, inval=0, WORDS=4:
  - 4 reads on words 0..3 in cycles 1-4, dir_update_o in cycle 4 with inval=0.
  - Req addr 0x2460 id 0, then 4 beats with last on beat 3.
  - After resp id 0, empty_o=1.
- Flush with inval=1: dir_update_inval_o=1 on the single update strobe. Beat data equals words preloaded into the data array model.
- Backpressure: mem_req_ready_i low 5 cycles, mem_data_ready_i toggling → addr/id/data stay stable while not accepted. Exactly 4 beats are sent, no duplicates.
- Table full: 4 flushes with no responses → 5th alloc_i held with alloc_ready_o=0. A response on id 2 lets the 5th be accepted with id 2 next cycle.
- Conflict check: during READ and while outstanding, check_nline_i=flushed nline → check_hit_o=1. It drops the cycle after the matching response. A different nline gives 0.
- Reset asserted during SEND_DATA beat 1 → all valids 0 immediately, empty_o=1 after release, new flush completes normally.

Source files
------------

// File: rtl/hpdcache_pkg.sv
// rtl/hpdcache_pkg.sv - shared types for the flush write-back path
package hpdcache_pkg;

  localparam int unsigned HPDCACHE_NLINE_W = 40;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND_REQ,
    SEND_DATA
  } hpdcache_flush_wb_fsm_t;

  typedef struct packed {
    logic                        valid;
    logic [HPDCACHE_NLINE_W-1:0] nline;
  } hpdcache_flush_entry_t;

endpackage

// File: rtl/hpdcache_flush_wb_table.sv
// rtl/hpdcache_flush_wb_table.sv - outstanding write table: ID allocation, release, line CAM
module hpdcache_flush_wb_table
  import hpdcache_pkg::*;
#(
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned NLINE_W = HPDCACHE_NLINE_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               alloc,
  input  logic [NLINE_W-1:0] alloc_nline,
  output logic [ID_W-1:0]    alloc_id,
  output logic               full,
  input  logic               free,
  input  logic [ID_W-1:0]    free_id,
  input  logic [NLINE_W-1:0] check_nline,
  output logic               check_hit,
  output logic               empty
);

  hpdcache_flush_entry_t entries_q [MAX_OUT];

  // Scan from the top so the lowest free index is the one left in alloc_id.
  always_comb begin
    alloc_id  = '0;
    full      = 1'b1;
    empty     = 1'b1;
    check_hit = 1'b0;
    for (int i = MAX_OUT - 1; i >= 0; i--) begin
      if (!entries_q[i].valid) begin
        alloc_id = ID_W'(i);
        full     = 1'b0;
      end else begin
        empty = 1'b0;
        if (entries_q[i].nline == check_nline) check_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MAX_OUT; i++) entries_q[i] <= '0;
    end else begin
      if (free && entries_q[free_id].valid) entries_q[free_id].valid <= 1'b0;
      if (alloc) begin
        entries_q[alloc_id].valid <= 1'b1;
        entries_q[alloc_id].nline <= alloc_nline;
      end
    end
  end

  ack_for_busy_entry : assert property (@(posedge clk_i) disable iff (!rst_ni)
    free |-> entries_q[free_id].valid);

endmodule

// File: rtl/hpdcache_flush_wb.sv
// rtl/hpdcache_flush_wb.sv - dirty line flush: read line, update directory, write to memory
module hpdcache_flush_wb
  import hpdcache_pkg::*;
#(
  parameter int unsigned NLINE_W  = HPDCACHE_NLINE_W,
  parameter int unsigned SET_W    = 7,
  parameter int unsigned WAYS     = 4,
  parameter int unsigned WORDS    = 4,
  parameter int unsigned WORD_W   = 64,
  parameter int unsigned CL_OFF_W = 5,
  parameter int unsigned MAX_OUT  = 4,
  parameter int unsigned ID_W     = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        alloc_i,
  output logic                        alloc_ready_o,
  input  logic [NLINE_W-1:0]          alloc_nline_i,
  input  logic [WAYS-1:0]             alloc_way_i,
  input  logic                        alloc_inval_i,
  output logic                        data_read_o,
  output logic [SET_W-1:0]            data_read_set_o,
  output logic [WAYS-1:0]             data_read_way_o,
  output logic [$clog2(WORDS)-1:0]    data_read_word_o,
  input  logic [WORD_W-1:0]           data_read_data_i,
  output logic                        dir_update_o,
  output logic [SET_W-1:0]            dir_update_set_o,
  output logic [WAYS-1:0]             dir_update_way_o,
  output logic                        dir_update_inval_o,
  output logic                        mem_req_valid_o,
  input  logic                        mem_req_ready_i,
  output logic [NLINE_W+CL_OFF_W-1:0] mem_req_addr_o,
  output logic [ID_W-1:0]             mem_req_id_o,
  output logic                        mem_data_valid_o,
  input  logic                        mem_data_ready_i,
  output logic [WORD_W-1:0]           mem_data_o,
  output logic                        mem_data_last_o,
  input  logic                        mem_resp_valid_i,
  input  logic [ID_W-1:0]             mem_resp_id_i,
  input  logic [NLINE_W-1:0]          check_nline_i,
  output logic                        check_hit_o,
  output logic                        empty_o
);

  localparam int unsigned IDX_W = $clog2(WORDS);
  localparam int unsigned CNT_W = $clog2(WORDS + 1);

  hpdcache_flush_wb_fsm_t state_q, state_d;
  logic [NLINE_W-1:0] nline_q;
  logic [WAYS-1:0]    way_q;
  logic               inval_q;
  logic [ID_W-1:0]    id_q;
  logic [CNT_W-1:0]   rd_cnt_q;
  logic [IDX_W-1:0]   beat_q;
  logic [WORD_W-1:0]  line_buf_q [WORDS];

  logic            tbl_full, tbl_empty, tbl_hit;
  logic [ID_W-1:0] tbl_id;
  logic            accept, data_hs;
  logic [IDX_W-1:0] cap_idx;

  assign alloc_ready_o = (state_q == IDLE) && !tbl_full;
  assign accept        = alloc_i && alloc_ready_o;
  assign data_hs       = mem_data_valid_o && mem_data_ready_i;
  assign cap_idx       = IDX_W'(rd_cnt_q - CNT_W'(1));

  hpdcache_flush_wb_table #(
    .MAX_OUT (MAX_OUT),
    .ID_W    (ID_W),
    .NLINE_W (NLINE_W)
  ) u_table (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .alloc       (accept),
    .alloc_nline (alloc_nline_i),
    .alloc_id    (tbl_id),
    .full        (tbl_full),
    .free        (mem_resp_valid_i),
    .free_id     (mem_resp_id_i),
    .check_nline (check_nline_i),
    .check_hit   (tbl_hit),
    .empty       (tbl_empty)
  );

  always_comb begin
    state_d          = state_q;
    data_read_o      = 1'b0;
    dir_update_o     = 1'b0;
    mem_req_valid_o  = 1'b0;
    mem_data_valid_o = 1'b0;
    case (state_q)
      IDLE: if (accept) state_d = READ;
      READ: begin
        // One extra cycle after the last strobe to capture the final word.
        data_read_o  = rd_cnt_q < CNT_W'(WORDS);
        dir_update_o = rd_cnt_q == CNT_W'(WORDS - 1);
        if (rd_cnt_q == CNT_W'(WORDS)) state_d = SEND_REQ;
      end
      SEND_REQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) state_d = SEND_DATA;
      end
      SEND_DATA: begin
        mem_data_valid_o = 1'b1;
        if (mem_data_ready_i && beat_q == IDX_W'(WORDS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      nline_q  <= '0;
      way_q    <= '0;
      inval_q  <= 1'b0;
      id_q     <= '0;
      rd_cnt_q <= '0;
      beat_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        nline_q  <= alloc_nline_i;
        way_q    <= alloc_way_i;
        inval_q  <= alloc_inval_i;
        id_q     <= tbl_id;
        rd_cnt_q <= '0;
        beat_q   <= '0;
      end
      if (state_q == READ) rd_cnt_q <= rd_cnt_q + CNT_W'(1);
      if (data_hs) beat_q <= beat_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == READ && rd_cnt_q != '0) line_buf_q[cap_idx] <= data_read_data_i;
  end

  assign data_read_set_o    = nline_q[SET_W-1:0];
  assign data_read_way_o    = way_q;
  assign data_read_word_o   = rd_cnt_q[IDX_W-1:0];
  assign dir_update_set_o   = nline_q[SET_W-1:0];
  assign dir_update_way_o   = way_q;
  assign dir_update_inval_o = inval_q;
  assign mem_req_addr_o     = {nline_q, {CL_OFF_W{1'b0}}};
  assign mem_req_id_o       = id_q;
  assign mem_data_o         = line_buf_q[beat_q];
  assign mem_data_last_o    = beat_q == IDX_W'(WORDS - 1);
  assign empty_o            = (state_q == IDLE) && tbl_empty;
  assign check_hit_o        = tbl_hit || (state_q != IDLE && nline_q == check_nline_i);

endmodule

// File: tb/tb_hpdcache_flush_wb.sv
// tb/tb_hpdcache_flush_wb.sv - randomized self-checking bench for hpdcache_flush_wb
module tb_hpdcache_flush_wb;

  logic        clk, rst_ni;
  logic        alloc_i, alloc_ready_o;
  logic [39:0] alloc_nline_i;
  logic [3:0]  alloc_way_i;
  logic        alloc_inval_i;
  logic        data_read_o;
  logic [6:0]  data_read_set_o;
  logic [3:0]  data_read_way_o;
  logic [1:0]  data_read_word_o;
  logic [63:0] data_read_data_i;
  logic        dir_update_o;
  logic [6:0]  dir_update_set_o;
  logic [3:0]  dir_update_way_o;
  logic        dir_update_inval_o;
  logic        mem_req_valid_o, mem_req_ready_i;
  logic [44:0] mem_req_addr_o;
  logic [1:0]  mem_req_id_o;
  logic        mem_data_valid_o, mem_data_ready_i;
  logic [63:0] mem_data_o;
  logic        mem_data_last_o;
  logic        mem_resp_valid_i;
  logic [1:0]  mem_resp_id_i;
  logic [39:0] check_nline_i;
  logic        check_hit_o, empty_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] dmem [128][4][4];
  bit          busy [4];
  logic [39:0] mnline [4];

  hpdcache_flush_wb dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .alloc_i(alloc_i), .alloc_ready_o(alloc_ready_o), .alloc_nline_i(alloc_nline_i),
    .alloc_way_i(alloc_way_i), .alloc_inval_i(alloc_inval_i),
    .data_read_o(data_read_o), .data_read_set_o(data_read_set_o), .data_read_way_o(data_read_way_o),
    .data_read_word_o(data_read_word_o), .data_read_data_i(data_read_data_i),
    .dir_update_o(dir_update_o), .dir_update_set_o(dir_update_set_o), .dir_update_way_o(dir_update_way_o),
    .dir_update_inval_o(dir_update_inval_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i), .mem_req_addr_o(mem_req_addr_o),
    .mem_req_id_o(mem_req_id_o), .mem_data_valid_o(mem_data_valid_o), .mem_data_ready_i(mem_data_ready_i),
    .mem_data_o(mem_data_o), .mem_data_last_o(mem_data_last_o),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_id_i(mem_resp_id_i),
    .check_nline_i(check_nline_i), .check_hit_o(check_hit_o), .empty_o(empty_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int oh2idx(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return i;
    return 0;
  endfunction

  function automatic int lowest_free();
    for (int i = 0; i < 4; i++) if (!busy[i]) return i;
    return -1;
  endfunction

  function automatic bit model_empty();
    for (int i = 0; i < 4; i++) if (busy[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Data array model: one-cycle read latency.
  always @(posedge clk)
    if (data_read_o) data_read_data_i <= dmem[data_read_set_o][oh2idx(data_read_way_o)][data_read_word_o];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_resp(input int id);
    mem_resp_valid_i = 1'b1;
    mem_resp_id_i    = 2'(id);
    tick();
    mem_resp_valid_i = 1'b0;
    busy[id] = 1'b0;
  endtask

  task automatic flush_one(input logic [39:0] nl, input logic [3:0] way, input bit inv,
                           input int stall, input bit toggle, input int abort_beat);
    int eid, wi, b, cyc;
    logic [63:0] exp_w [4];
    wi  = oh2idx(way);
    eid = lowest_free();
    for (int k = 0; k < 4; k++) exp_w[k] = dmem[nl[6:0]][wi][k];
    alloc_i = 1'b1; alloc_nline_i = nl; alloc_way_i = way; alloc_inval_i = inv;
    check_nline_i = nl;
    #1;
    n_cmp++;
    if (alloc_ready_o !== 1'b1) begin
      n_err++; $display("FAIL alloc_ready: got %b want 1", alloc_ready_o);
    end
    tick();
    alloc_i = 1'b0;
    busy[eid] = 1'b1; mnline[eid] = nl;
    for (int k = 0; k <= 4; k++) begin
      #1;
      n_cmp++;
      if ({data_read_o, dir_update_o, check_hit_o} !== {1'(k < 4), 1'(k == 3), 1'b1}) begin
        n_err++; $display("FAIL read_ctl cyc%0d: rd/upd/hit got %b%b%b want %b%b1", k,
                          data_read_o, dir_update_o, check_hit_o, k < 4, k == 3);
      end
      if (k < 4) begin
        n_cmp++;
        if ({data_read_word_o, data_read_set_o, data_read_way_o} !== {2'(k), nl[6:0], way} ||
            (k == 3 && {dir_update_set_o, dir_update_way_o, dir_update_inval_o} !== {nl[6:0], way, inv})) begin
          n_err++; $display("FAIL read_addr cyc%0d: word %0d set %h way %b inval %b want %0d %h %b %b", k,
                            data_read_word_o, data_read_set_o, data_read_way_o, dir_update_inval_o,
                            k, nl[6:0], way, inv);
        end
      end
      tick();
    end
    for (int i = 0; i <= stall; i++) begin
      mem_req_ready_i = (i == stall);
      #1;
      n_cmp++;
      if ({mem_req_valid_o, mem_req_addr_o, mem_req_id_o, mem_data_valid_o} !== {1'b1, nl, 5'b0, 2'(eid), 1'b0}) begin
        n_err++; $display("FAIL mem_req: valid %b addr %h id %0d got, want 1 %h %0d", mem_req_valid_o,
                          mem_req_addr_o, mem_req_id_o, {nl, 5'b0}, eid);
      end
      tick();
    end
    mem_req_ready_i = 1'b0;
    b = 0; cyc = 0;
    while (b < 4 && cyc < 64) begin
      mem_data_ready_i = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (b == abort_beat) begin
        rst_ni = 1'b0;
        #1;
        n_cmp++;
        if ({mem_req_valid_o, mem_data_valid_o, data_read_o, dir_update_o} !== 4'b0) begin
          n_err++; $display("FAIL abort_valids: got %b want 0000",
                            {mem_req_valid_o, mem_data_valid_o, data_read_o, dir_update_o});
        end
        mem_data_ready_i = 1'b0;
        return;
      end
      n_cmp++;
      if ({mem_data_valid_o, mem_data_o, mem_data_last_o} !== {1'b1, exp_w[b], 1'(b == 3)}) begin
        n_err++; $display("FAIL beat%0d: valid %b data %h last %b want 1 %h %b", b,
                          mem_data_valid_o, mem_data_o, mem_data_last_o, exp_w[b], b == 3);
      end
      if (mem_data_ready_i) b++;
      cyc++;
      tick();
    end
    mem_data_ready_i = 1'b0;
    n_cmp++;
    if (b != 4) begin
      n_err++; $display("FAIL beat_timeout: sent %0d beats want 4", b);
    end
    #1;
    n_cmp++;
    if ({mem_data_valid_o, mem_req_valid_o, alloc_ready_o} !== {2'b00, 1'(lowest_free() >= 0)}) begin
      n_err++; $display("FAIL post_flush: dvalid %b rvalid %b ready %b want 0 0 %b",
                        mem_data_valid_o, mem_req_valid_o, alloc_ready_o, lowest_free() >= 0);
    end
    tick();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    alloc_i = 0; alloc_nline_i = '0; alloc_way_i = '0; alloc_inval_i = 0;
    mem_req_ready_i = 0; mem_data_ready_i = 0; mem_resp_valid_i = 0; mem_resp_id_i = '0;
    check_nline_i = '0;
    for (int i = 0; i < 4; i++) busy[i] = 1'b0;
    repeat (3) tick();
    rst_ni = 1'b1;
    #1;
    n_cmp++;
    if ({alloc_ready_o, empty_o, data_read_o, dir_update_o, mem_req_valid_o, mem_data_valid_o, check_hit_o} !== 7'b1100000) begin
      n_err++; $display("FAIL reset_state: got %b want 1100000",
                        {alloc_ready_o, empty_o, data_read_o, dir_update_o, mem_req_valid_o, mem_data_valid_o, check_hit_o});
    end
    tick();
  endtask

  task automatic test_clean_flush();
    flush_one(40'h123, 4'b0010, 1'b0, 0, 1'b0, -1);
    n_cmp++;
    if (empty_o !== 1'b0) begin
      n_err++; $display("FAIL clean_not_empty: got %b want 0", empty_o);
    end
    send_resp(0);
    n_cmp++;
    if (empty_o !== 1'b1) begin
      n_err++; $display("FAIL clean_empty: got %b want 1", empty_o);
    end
  endtask

  task automatic test_inval_flush();
    logic [39:0] nl;
    nl = {$urandom, $urandom};
    flush_one(nl, 4'b1000, 1'b1, 0, 1'b0, -1);
    send_resp(0);
  endtask

  task automatic test_backpressure();
    logic [39:0] nl;
    nl = {$urandom, $urandom};
    flush_one(nl, 4'b0100, 1'($urandom_range(0, 1)), 5, 1'b1, -1);
    send_resp(0);
  endtask

  task automatic test_table_full();
    for (int i = 0; i < 4; i++)
      flush_one({$urandom, $urandom}, 4'b1 << $urandom_range(0, 3), 1'b0, 0, 1'b0, -1);
    alloc_i = 1'b1; alloc_nline_i = 40'hABCDE; alloc_way_i = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin mem_resp_valid_i = 1'b1; mem_resp_id_i = 2'd2; end
      #1;
      n_cmp++;
      if (alloc_ready_o !== 1'b0) begin
        n_err++; $display("FAIL full_ready cyc%0d: got %b want 0", i, alloc_ready_o);
      end
      tick();
    end
    mem_resp_valid_i = 1'b0;
    busy[2] = 1'b0;
    flush_one(40'hABCDE, 4'b0001, 1'b0, 1, 1'b0, -1);
    for (int i = 0; i < 4; i++) send_resp(i);
    #1;
    n_cmp++;
    if (empty_o !== 1'b1) begin
      n_err++; $display("FAIL full_drain_empty: got %b want 1", empty_o);
    end
    tick();
  endtask

  task automatic test_conflict();
    logic [39:0] nl;
    nl = {$urandom, $urandom};
    flush_one(nl, 4'b0001, 1'b0, 0, 1'b0, -1);
    check_nline_i = nl ^ 40'h1;
    #1;
    n_cmp++;
    if (check_hit_o !== 1'b0) begin
      n_err++; $display("FAIL conflict_other: got %b want 0", check_hit_o);
    end
    check_nline_i = nl;
    mem_resp_valid_i = 1'b1; mem_resp_id_i = 2'd0;
    #1;
    n_cmp++;
    if (check_hit_o !== 1'b1) begin
      n_err++; $display("FAIL conflict_outstanding: got %b want 1", check_hit_o);
    end
    tick();
    mem_resp_valid_i = 1'b0;
    busy[0] = 1'b0;
    #1;
    n_cmp++;
    if (check_hit_o !== 1'b0) begin
      n_err++; $display("FAIL conflict_after_ack: got %b want 0", check_hit_o);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    flush_one({$urandom, $urandom}, 4'b0010, 1'b1, 0, 1'b0, 1);
    tick();
    for (int i = 0; i < 4; i++) busy[i] = 1'b0;
    rst_ni = 1'b1;
    #1;
    n_cmp++;
    if ({empty_o, alloc_ready_o} !== 2'b11) begin
      n_err++; $display("FAIL reset_mid_state: empty/ready got %b want 11", {empty_o, alloc_ready_o});
    end
    tick();
    flush_one({$urandom, $urandom}, 4'b0100, 1'b0, 0, 1'b0, -1);
    send_resp(0);
  endtask

  task automatic test_random();
    int id, start;
    for (int it = 0; it < 12; it++) begin
      if (lowest_free() < 0 || $urandom_range(0, 1) == 1) begin
        start = $urandom_range(0, 3);
        id = -1;
        for (int j = 0; j < 4; j++) if (id < 0 && busy[(start + j) % 4]) id = (start + j) % 4;
        if (id >= 0) send_resp(id);
      end
      flush_one({$urandom, $urandom}, 4'b1 << $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), 1'b1, -1);
      id = $urandom_range(0, 3);
      if (busy[id]) begin
        check_nline_i = mnline[id];
        #1;
        n_cmp++;
        if ({check_hit_o, empty_o} !== 2'b10) begin
          n_err++; $display("FAIL rand_hit id%0d: hit/empty got %b want 10", id, {check_hit_o, empty_o});
        end
        tick();
      end
    end
    for (int i = 0; i < 4; i++) if (busy[i]) send_resp(i);
    #1;
    n_cmp++;
    if (empty_o !== model_empty()) begin
      n_err++; $display("FAIL rand_empty: got %b want %b", empty_o, model_empty());
    end
    tick();
  endtask

  initial begin
    for (int s = 0; s < 128; s++)
      for (int w = 0; w < 4; w++)
        for (int k = 0; k < 4; k++) dmem[s][w][k] = {$urandom, $urandom};
    test_reset();
    test_clean_flush();
    test_inval_flush();
    test_backpressure();
    test_table_full();
    test_conflict();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
